// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch path.
package cpu_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_fetch_buffer.sv
// Two-entry in-order instruction buffer. Entry 0 is the head (IR) and
// entry 1 the prefetch slot. Each entry carries the word and its address.
module fetch_buffer
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic [ADDR_W-1:0] push_pc_i,
    output logic [1:0]        occ_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic [ADDR_W-1:0] head_pc_o
);

    logic [DATA_W-1:0] data0_q, data1_q;
    logic [ADDR_W-1:0] pc0_q, pc1_q;
    logic [1:0]        occ_q;

    // Entry storage: clear wins, then pop/push; a pop shifts the prefetch into the head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q   <= 2'd0;
            data0_q <= '0;
            data1_q <= '0;
            pc0_q   <= RESET_PC;
            pc1_q   <= RESET_PC;
        end else if (clear_i) begin
            occ_q <= 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b11: begin
                    if (occ_q == 2'd2) begin
                        data0_q <= data1_q;
                        pc0_q   <= pc1_q;
                        data1_q <= push_data_i;
                        pc1_q   <= push_pc_i;
                    end else begin
                        data0_q <= push_data_i;
                        pc0_q   <= push_pc_i;
                    end
                end
                2'b01: begin
                    // Only shift when the prefetch slot holds a real word so a
                    // drained head keeps its last value rather than stale data.
                    if (occ_q == 2'd2) begin
                        data0_q <= data1_q;
                        pc0_q   <= pc1_q;
                    end
                    occ_q <= occ_q - 2'd1;
                end
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        data0_q <= push_data_i;
                        pc0_q   <= push_pc_i;
                    end else begin
                        data1_q <= push_data_i;
                        pc1_q   <= push_pc_i;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign occ_o       = occ_q;
    assign head_data_o = data0_q;
    assign head_pc_o   = pc0_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words over a req/ack
// handshake, buffers IR + one prefetch and hands IR to the control FSM.
module instr_fetch_unit
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] ir_o,
    output logic              ir_valid_o,
    input  logic              ir_ready_i,
    output logic [ADDR_W-1:0] ir_pc_o,
    output logic [ADDR_W-1:0] ir_pc_next_o,
    input  logic              redirect_en_i,
    input  logic [ADDR_W-1:0] redirect_pc_i
);

    fetch_state_t      state_q;
    logic              mem_req_q;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] mem_addr_q;

    logic [1:0]        occ;
    logic              consume;
    logic              push;
    logic              ack;
    logic [1:0]        space;

    // An ack only counts while a request is actually on the bus.
    assign ack     = mem_ack_i & mem_req_q;
    assign consume = ir_valid_o & ir_ready_i & ~redirect_en_i;
    assign push    = (state_q == REQ) & ack & ~redirect_en_i;
    assign space   = 2'd2 - occ + {1'b0, consume};

    fetch_buffer u_buf (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .pop_i       (consume),
        .clear_i     (redirect_en_i),
        .push_data_i (mem_rdata_i),
        .push_pc_i   (mem_addr_q),
        .occ_o       (occ),
        .head_data_o (ir_o),
        .head_pc_o   (ir_pc_o)
    );

    // Fetch FSM with registered request/address; redirect has top priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            fetch_pc_q <= RESET_PC;
            mem_addr_q <= RESET_PC;
        end else begin
            case (state_q)
                IDLE: begin
                    if (redirect_en_i) begin
                        fetch_pc_q <= redirect_pc_i;
                        mem_addr_q <= redirect_pc_i;
                        state_q    <= REQ;
                        mem_req_q  <= 1'b1;
                    end else if (space != 2'd0) begin
                        mem_addr_q <= fetch_pc_q;
                        state_q    <= REQ;
                        mem_req_q  <= 1'b1;
                    end
                end
                REQ: begin
                    if (redirect_en_i) begin
                        fetch_pc_q <= redirect_pc_i;
                        if (ack) begin
                            mem_addr_q <= redirect_pc_i;
                        end else begin
                            // Outstanding request must complete at its original address.
                            state_q <= FLUSH;
                        end
                    end else if (ack) begin
                        fetch_pc_q <= fetch_pc_q + 1'b1;
                        if (space > 2'd1) begin
                            mem_addr_q <= fetch_pc_q + 1'b1;
                        end else begin
                            state_q   <= IDLE;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    if (redirect_en_i) begin
                        fetch_pc_q <= redirect_pc_i;
                    end
                    if (ack) begin
                        state_q    <= REQ;
                        mem_addr_q <= redirect_en_i ? redirect_pc_i : fetch_pc_q;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = mem_addr_q;
    assign ir_valid_o   = (occ != 2'd0);
    assign ir_pc_next_o = ir_pc_o + 1'b1;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-configurable memory.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] ir;
    logic        ir_valid;
    logic        ir_ready;
    logic [15:0] ir_pc;
    logic [15:0] ir_pc_next;
    logic        redirect_en;
    logic [15:0] redirect_pc;

    int          n_cmp = 0;
    int          n_bad = 0;

    logic        mem_en;
    logic        force_ack;
    int          lat;
    int          wait_cnt;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_ack_i     (mem_ack),
        .mem_rdata_i   (mem_rdata),
        .ir_o          (ir),
        .ir_valid_o    (ir_valid),
        .ir_ready_i    (ir_ready),
        .ir_pc_o       (ir_pc),
        .ir_pc_next_o  (ir_pc_next),
        .redirect_en_i (redirect_en),
        .redirect_pc_i (redirect_pc)
    );

    // Memory content is a fixed function of the address.
    function automatic logic [15:0] word_at(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    assign mem_rdata = word_at(mem_addr);
    assign mem_ack   = force_ack | (mem_en & mem_req & (wait_cnt >= lat));

    always @(posedge clk) begin
        if (!mem_req || mem_ack) wait_cnt <= 0;
        else                     wait_cnt <= wait_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ir_ready = 1'b0; redirect_en = 1'b0; redirect_pc = 16'h0;
        mem_en = 1'b0; force_ack = 1'b0; lat = 0; wait_cnt = 0;
        step(); step();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_ir_valid", ir_valid, 0);
        chk("rst_ir", ir, 16'h0000);
        chk("rst_ir_pc", ir_pc, 16'h0000);
        chk("rst_ir_pc_next", ir_pc_next, 16'h0001);

        // 1: zero-wait streaming
        mem_en = 1'b1; lat = 0; ir_ready = 1'b1;
        reset = 1'b0;
        chk("t1_idle_req", mem_req, 0);
        step();
        chk("t1_req", mem_req, 1);
        chk("t1_addr0", mem_addr, 16'h0000);
        chk("t1_nvalid", ir_valid, 0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("t1_addr", mem_addr, i[15:0]);
            chk("t1_valid", ir_valid, 1);
            chk("t1_ir_pc", ir_pc, i[15:0] - 16'd1);
            chk("t1_ir", ir, word_at(i[15:0] - 16'd1));
        end

        // 2: backpressure fills the buffer, one consume reopens fetching
        ir_ready = 1'b0;
        do_reset();
        step();
        chk("t2_addr0", mem_addr, 16'h0000);
        step();
        chk("t2_addr1", mem_addr, 16'h0001);
        step();
        chk("t2_req_off", mem_req, 0);
        chk("t2_ir_pc", ir_pc, 16'h0000);
        step();
        chk("t2_req_off2", mem_req, 0);
        chk("t2_ir_hold", ir, 16'hC3A5);
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        chk("t2_ir_pfb", ir, 16'hC3A4);
        chk("t2_ir_pc_pfb", ir_pc, 16'h0001);
        chk("t2_req_again", mem_req, 1);
        chk("t2_addr2", mem_addr, 16'h0002);

        // 3: redirect while a slow fetch is outstanding
        lat = 3; ir_ready = 1'b1;
        do_reset();
        step();
        chk("t3_req", mem_req, 1);
        step();
        redirect_en = 1'b1; redirect_pc = 16'h0040;
        step();
        redirect_en = 1'b0;
        chk("t3_flush_req", mem_req, 1);
        chk("t3_flush_addr", mem_addr, 16'h0000);
        chk("t3_flush_nvalid", ir_valid, 0);
        step();
        chk("t3_ack_nvalid", ir_valid, 0);
        step();
        chk("t3_new_addr", mem_addr, 16'h0040);
        chk("t3_new_nvalid", ir_valid, 0);
        step(); step(); step();
        chk("t3_wait_nvalid", ir_valid, 0);
        step();
        chk("t3_valid", ir_valid, 1);
        chk("t3_ir_pc", ir_pc, 16'h0040);
        chk("t3_ir", ir, 16'hC3E5);

        // 4: redirect coincident with ack and consume
        lat = 0; ir_ready = 1'b1;
        do_reset();
        step();
        step();
        chk("t4_pre_valid", ir_valid, 1);
        redirect_en = 1'b1; redirect_pc = 16'h0100;
        step();
        redirect_en = 1'b0;
        chk("t4_nvalid", ir_valid, 0);
        chk("t4_addr", mem_addr, 16'h0100);
        chk("t4_req", mem_req, 1);
        step();
        chk("t4_valid", ir_valid, 1);
        chk("t4_ir_pc", ir_pc, 16'h0100);
        chk("t4_ir", ir, 16'hC2A5);

        // 5: PC wrap
        redirect_en = 1'b1; redirect_pc = 16'hFFFF;
        step();
        redirect_en = 1'b0;
        chk("t5_nvalid", ir_valid, 0);
        chk("t5_addr_ffff", mem_addr, 16'hFFFF);
        step();
        chk("t5_ir_pc", ir_pc, 16'hFFFF);
        chk("t5_ir_pc_next", ir_pc_next, 16'h0000);
        chk("t5_ir", ir, 16'h3C5A);
        chk("t5_addr_0", mem_addr, 16'h0000);
        step();
        chk("t5_ir_pc_wrap", ir_pc, 16'h0000);
        chk("t5_ir_pc_next1", ir_pc_next, 16'h0001);

        // 6: reset mid-request, then a stray ack
        lat = 3; ir_ready = 1'b1;
        do_reset();
        step();
        chk("t6_req", mem_req, 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_req", mem_req, 0);
        chk("t6_rst_valid", ir_valid, 0);
        chk("t6_rst_ir_pc", ir_pc, 16'h0000);
        mem_en = 1'b0;
        step();
        reset = 1'b0; force_ack = 1'b1;
        #1;
        chk("t6_idle_req", mem_req, 0);
        step();
        force_ack = 1'b0; mem_en = 1'b1;
        chk("t6_stray_nvalid", ir_valid, 0);
        chk("t6_refetch_req", mem_req, 1);
        chk("t6_refetch_addr", mem_addr, 16'h0000);
        step(); step(); step(); step();
        chk("t6_valid", ir_valid, 1);
        chk("t6_ir_pc", ir_pc, 16'h0000);
        chk("t6_ir", ir, 16'hC3A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
